// File: rtl/mdu_issue_controller.sv
// Issues MDU-class instructions from EX to the multiply/divide unit and holds EX while an operation is in flight.
// Combinational issue/stall; registered mfhi/mflo response one cycle after accept; perf counters and sticky timeout.
module mdu_issue_controller #(
  parameter int MUL_CYCLES    = 5,
  parameter int DIV_CYCLES    = 10,
  parameter int TIMEOUT_SLACK = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic        req_kill,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [31:0] mdu_operand1,
  output logic [31:0] mdu_operand2,
  output logic [2:0]  mdu_operation,
  output logic        mdu_start,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_data_read,
  output logic [31:0] perf_mul_count,
  output logic [31:0] perf_div_count,
  output logic [31:0] perf_stall_cycles,
  output logic        err_timeout
);

  // Timeout fires on the cycle the wait counter would reach the limit.
  localparam logic [15:0] MUL_LAST = 16'(MUL_CYCLES + TIMEOUT_SLACK - 1);
  localparam logic [15:0] DIV_LAST = 16'(DIV_CYCLES + TIMEOUT_SLACK - 1);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_e;

  state_e      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [31:0] mul_cnt_q, div_cnt_q, stall_cnt_q;
  logic        accept;
  logic        is_mul, is_div;

  assign stall  = req_valid & ~req_kill & ((state_q != IDLE) | mdu_busy);
  // Gating with reset keeps start low and the operation at READ_HI while the MDU is held in reset.
  assign accept = req_valid & ~req_kill & ~stall & reset;
  assign is_mul = accept & req_op[2] & ~req_op[1];
  assign is_div = accept & req_op[2] & req_op[1];

  // WRITE_HI/WRITE_LO must only reach the MDU in an accept cycle, so idle drives READ_HI.
  assign mdu_operation = accept ? req_op : 3'd0;
  assign mdu_start     = accept & req_op[2];
  assign mdu_operand1  = req_rs;
  assign mdu_operand2  = req_rt;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (is_mul) begin
          state_d = MUL_WAIT;
          wcnt_d  = '0;
        end else if (is_div) begin
          state_d = DIV_WAIT;
          wcnt_d  = '0;
        end
      end
      MUL_WAIT, DIV_WAIT: begin
        if (!mdu_busy) begin
          state_d = IDLE;
        end else if (wcnt_q == ((state_q == DIV_WAIT) ? DIV_LAST : MUL_LAST)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_valid_d = accept & ~req_op[2] & ~req_op[1];
  assign resp_data_d  = resp_valid_d ? mdu_data_read : resp_data_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      mul_cnt_q    <= '0;
      div_cnt_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      mul_cnt_q    <= mul_cnt_q + {31'd0, is_mul};
      div_cnt_q    <= div_cnt_q + {31'd0, is_div};
      stall_cnt_q  <= stall_cnt_q + {31'd0, stall};
    end
  end

  assign resp_valid        = resp_valid_q;
  assign resp_data         = resp_data_q;
  assign perf_mul_count    = mul_cnt_q;
  assign perf_div_count    = div_cnt_q;
  assign perf_stall_cycles = stall_cnt_q;
  assign err_timeout       = err_q;

endmodule

// File: tb/tb_mdu_issue_controller.sv
// Directed bench for mdu_issue_controller with a behavioural MDU attached.
module tb_mdu_issue_controller;

  localparam int MUL_BUSY = 4;
  localparam int DIV_BUSY = 9;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_rs, req_rt;
  logic        req_kill;
  logic        stall, resp_valid, mdu_start, mdu_busy, err_timeout;
  logic [31:0] resp_data, mdu_operand1, mdu_operand2, mdu_data_read;
  logic [2:0]  mdu_operation;
  logic [31:0] perf_mul_count, perf_div_count, perf_stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mdu_issue_controller #(.MUL_CYCLES(5), .DIV_CYCLES(10), .TIMEOUT_SLACK(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_kill(req_kill), .stall(stall),
    .resp_valid(resp_valid), .resp_data(resp_data), .mdu_operand1(mdu_operand1),
    .mdu_operand2(mdu_operand2), .mdu_operation(mdu_operation), .mdu_start(mdu_start),
    .mdu_busy(mdu_busy), .mdu_data_read(mdu_data_read), .perf_mul_count(perf_mul_count),
    .perf_div_count(perf_div_count), .perf_stall_cycles(perf_stall_cycles),
    .err_timeout(err_timeout)
  );

  // Behavioural MDU: busy from the cycle after start, HI/LO committed as busy falls.
  logic [31:0] hi_r = '0, lo_r = '0, p_hi = '0, p_lo = '0;
  int          busy_cnt = 0;
  logic        hang = 1'b0;
  logic [63:0] smul_w, umul_w;

  assign smul_w = {{32{mdu_operand1[31]}}, mdu_operand1} * {{32{mdu_operand2[31]}}, mdu_operand2};
  assign umul_w = {32'd0, mdu_operand1} * {32'd0, mdu_operand2};
  assign mdu_busy      = (busy_cnt != 0);
  assign mdu_data_read = (mdu_operation == 3'd1) ? lo_r : hi_r;

  always @(posedge clock) begin
    if (!reset) begin
      busy_cnt <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        hi_r <= p_hi;
        lo_r <= p_lo;
      end
    end else if (mdu_start) begin
      case (mdu_operation)
        3'd4: begin p_hi <= smul_w[63:32]; p_lo <= smul_w[31:0]; end
        3'd5: begin p_hi <= umul_w[63:32]; p_lo <= umul_w[31:0]; end
        3'd6: begin
          p_hi <= $signed(mdu_operand1) % $signed(mdu_operand2);
          p_lo <= $signed(mdu_operand1) / $signed(mdu_operand2);
        end
        default: begin
          p_hi <= mdu_operand1 % mdu_operand2;
          p_lo <= mdu_operand1 / mdu_operand2;
        end
      endcase
      busy_cnt <= hang ? 1000000 : (mdu_operation[1] ? DIV_BUSY : MUL_BUSY);
    end else if (mdu_operation == 3'd2) begin
      hi_r <= mdu_operand1;
    end else if (mdu_operation == 3'd3) begin
      lo_r <= mdu_operand1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_rs = '0; req_rt = '0; req_kill = 1'b0;
    tick(); tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
    checks++; if (perf_mul_count !== 32'd0 || perf_div_count !== 32'd0 || perf_stall_cycles !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", perf_mul_count, perf_div_count, perf_stall_cycles); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_timeout); end
    checks++; if (stall !== 1'b0 || mdu_start !== 1'b0 || mdu_operation !== 3'd0) begin
      errors++; $display("FAIL reset_drive got stall=%b start=%b op=%0d want 0/0/0", stall, mdu_start, mdu_operation); end
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_op = 3'd3; req_rs = 32'h1234; req_rt = 32'h0;
    #1;
    checks++; if (mdu_operation !== 3'd3 || mdu_start !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL mtlo_drive got op=%0d start=%b stall=%b want 3/0/0", mdu_operation, mdu_start, stall); end
    tick();
    req_op = 3'd1; req_rs = 32'h0;
    #1;
    checks++; if (mdu_operation !== 3'd1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL mflo_issue got op=%0d resp_valid=%b want 1/0", mdu_operation, resp_valid); end
    tick();
    req_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h1234) begin
      errors++; $display("FAIL mflo_resp got v=%b d=%h want 1/00001234", resp_valid, resp_data); end
    checks++; if (mdu_operation !== 3'd0) begin errors++; $display("FAIL idle_op got %0d want 0", mdu_operation); end
    tick();
    checks++; if (resp_valid !== 1'b0 || resp_data !== 32'h1234) begin
      errors++; $display("FAIL resp_hold got v=%b d=%h want 0/00001234", resp_valid, resp_data); end
  endtask

  task automatic test_smul();
    int n;
    req_valid = 1'b1; req_op = 3'd4; req_rs = 32'hFFFF_FFFD; req_rt = 32'd7;
    #1;
    checks++; if (mdu_start !== 1'b1 || stall !== 1'b0 || mdu_operand1 !== 32'hFFFF_FFFD || mdu_operand2 !== 32'd7) begin
      errors++; $display("FAIL smul_start got start=%b stall=%b a=%h b=%h want 1/0/fffffffd/00000007", mdu_start, stall, mdu_operand1, mdu_operand2); end
    tick();
    req_op = 3'd1;
    #1;
    checks++; if (stall !== 1'b1 || mdu_start !== 1'b0 || mdu_operation !== 3'd0) begin
      errors++; $display("FAIL smul_wait got stall=%b start=%b op=%0d want 1/0/0", stall, mdu_start, mdu_operation); end
    n = 0;
    while (stall && n < 30) begin n++; tick(); end
    checks++; if (n !== 5) begin errors++; $display("FAIL smul_stall_len got %0d want 5", n); end
    tick();
    req_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL smul_result got v=%b d=%h want 1/ffffffeb", resp_valid, resp_data); end
    checks++; if (perf_mul_count !== 32'd1 || perf_stall_cycles !== 32'd5) begin
      errors++; $display("FAIL smul_counters got mul=%0d stall=%0d want 1/5", perf_mul_count, perf_stall_cycles); end
  endtask

  task automatic test_back_to_back();
    int n;
    req_valid = 1'b1; req_op = 3'd7; req_rs = 32'd100; req_rt = 32'd7;
    #1;
    checks++; if (mdu_start !== 1'b1 || mdu_operation !== 3'd7) begin
      errors++; $display("FAIL udiv_start got start=%b op=%0d want 1/7", mdu_start, mdu_operation); end
    tick();
    req_op = 3'd0;
    #1;
    n = 0;
    while (stall && n < 30) begin n++; tick(); end
    checks++; if (n !== 10) begin errors++; $display("FAIL udiv_stall_len got %0d want 10", n); end
    tick();
    req_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd2) begin
      errors++; $display("FAIL udiv_hi got v=%b d=%h want 1/00000002", resp_valid, resp_data); end
    checks++; if (perf_div_count !== 32'd1 || perf_stall_cycles !== 32'd15) begin
      errors++; $display("FAIL udiv_counters got div=%0d stall=%0d want 1/15", perf_div_count, perf_stall_cycles); end
  endtask

  task automatic test_kill();
    int n;
    req_valid = 1'b1; req_op = 3'd6; req_rs = 32'd100; req_rt = 32'd7; req_kill = 1'b1;
    #1;
    checks++; if (mdu_start !== 1'b0 || stall !== 1'b0 || mdu_operation !== 3'd0) begin
      errors++; $display("FAIL kill_idle got start=%b stall=%b op=%0d want 0/0/0", mdu_start, stall, mdu_operation); end
    tick();
    req_kill = 1'b0; req_op = 3'd0;
    #1;
    checks++; if (stall !== 1'b0 || mdu_operation !== 3'd0) begin
      errors++; $display("FAIL kill_no_state got stall=%b op=%0d want 0/0", stall, mdu_operation); end
    tick();
    req_valid = 1'b0;
    #1;
    checks++; if (resp_data !== 32'd2 || perf_div_count !== 32'd1) begin
      errors++; $display("FAIL kill_no_count got d=%h div=%0d want 00000002/1", resp_data, perf_div_count); end
    req_valid = 1'b1; req_op = 3'd6; req_rs = 32'hFFFF_FF9C; req_rt = 32'd7;
    tick();
    req_op = 3'd0; req_kill = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL kill_wait_stall got %b want 0", stall); end
    tick(); tick(); tick();
    req_kill = 1'b0;
    #1;
    n = 0;
    while (stall && n < 30) begin n++; tick(); end
    checks++; if (n !== 7) begin errors++; $display("FAIL kill_wait_len got %0d want 7", n); end
    tick();
    req_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL sdiv_hi got v=%b d=%h want 1/fffffffe", resp_valid, resp_data); end
    checks++; if (perf_div_count !== 32'd2 || perf_stall_cycles !== 32'd22) begin
      errors++; $display("FAIL kill_counters got div=%0d stall=%0d want 2/22", perf_div_count, perf_stall_cycles); end
  endtask

  task automatic test_timeout();
    int n;
    hang = 1'b1;
    req_valid = 1'b1; req_op = 3'd4; req_rs = 32'd2; req_rt = 32'd3;
    #1;
    checks++; if (mdu_start !== 1'b1) begin errors++; $display("FAIL to_start got %b want 1", mdu_start); end
    tick();
    req_valid = 1'b0;
    #1;
    n = 0;
    while (!err_timeout && n < 30) begin n++; tick(); end
    checks++; if (n !== 7) begin errors++; $display("FAIL to_cycles got %0d want 7", n); end
    req_valid = 1'b1; req_op = 3'd0;
    #1;
    checks++; if (stall !== 1'b1 || mdu_operation !== 3'd0) begin
      errors++; $display("FAIL to_follow_busy got stall=%b op=%0d want 1/0", stall, mdu_operation); end
    tick(); tick(); tick();
    checks++; if (err_timeout !== 1'b1 || stall !== 1'b1 || perf_mul_count !== 32'd2) begin
      errors++; $display("FAIL to_sticky got err=%b stall=%b mul=%0d want 1/1/2", err_timeout, stall, perf_mul_count); end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    reset = 1'b0; hang = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (err_timeout !== 1'b0 || perf_mul_count !== 32'd0) begin
      errors++; $display("FAIL err_clear got err=%b mul=%0d want 0/0", err_timeout, perf_mul_count); end
    req_valid = 1'b1; req_op = 3'd7; req_rs = 32'd9; req_rt = 32'd2;
    tick();
    req_op = 3'd6;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (mdu_start !== 1'b0 || mdu_operation !== 3'd0) begin
      errors++; $display("FAIL rst_force got start=%b op=%0d want 0/0", mdu_start, mdu_operation); end
    tick();
    checks++; if (perf_mul_count !== 32'd0 || perf_div_count !== 32'd0 || perf_stall_cycles !== 32'd0 ||
                  resp_valid !== 1'b0 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear got mul=%0d div=%0d stall=%0d v=%b err=%b want 0/0/0/0/0",
                         perf_mul_count, perf_div_count, perf_stall_cycles, resp_valid, err_timeout); end
    reset = 1'b1; req_op = 3'd5; req_rs = 32'd6; req_rt = 32'd7;
    #1;
    checks++; if (stall !== 1'b0 || mdu_start !== 1'b1 || mdu_operation !== 3'd5) begin
      errors++; $display("FAIL rst_first_accept got stall=%b start=%b op=%0d want 0/1/5", stall, mdu_start, mdu_operation); end
    tick();
    req_valid = 1'b0;
    #1;
    checks++; if (perf_mul_count !== 32'd1) begin errors++; $display("FAIL rst_first_count got %0d want 1", perf_mul_count); end
    repeat (8) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_smul();
    test_back_to_back();
    test_kill();
    test_timeout();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_issue_controller.md
Name: mdu_issue_controller

Overview:
- Initiator side of the multiply/divide unit interface. Sits in the execute stage between the decoder and the MDU.
- Accepts one MDU-class instruction per cycle: mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- Drives the MDU operation, operand and start lines, and stalls the pipeline while a multiply or divide is in flight.
- Returns registered mfhi/mflo results, and keeps performance counters plus a sticky timeout error.

Parameters:
MUL_CYCLES, 5, MDU multiply latency in cycles; used for the timeout limit
DIV_CYCLES, 10, MDU divide latency in cycles; used for the timeout limit
TIMEOUT_SLACK, 2, extra cycles tolerated beyond the nominal latency before err_timeout is set

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  MDU-class instruction present in EX
req_op  in  3  operation: 0 READ_HI, 1 READ_LO, 2 WRITE_HI, 3 WRITE_LO, 4 SMUL, 5 UMUL, 6 SDIV, 7 UDIV
req_rs  in  32  rs value; operand1, also the mthi/mtlo data
req_rt  in  32  rt value; operand2
req_kill  in  1  flush of the EX instruction this cycle
stall  out  1  hold EX; the instruction is not accepted
resp_valid  out  1  registered mfhi/mflo result valid
resp_data  out  32  registered mfhi/mflo result
mdu_operand1  out  32  to MDU operand1
mdu_operand2  out  32  to MDU operand2
mdu_operation  out  3  to MDU operation
mdu_start  out  1  to MDU start
mdu_busy  in  1  from MDU busy
mdu_data_read  in  32  from MDU dataRead (combinational from mdu_operation)
perf_mul_count  out  32  accepted multiplies
perf_div_count  out  32  accepted divides
perf_stall_cycles  out  32  cycles with stall=1
err_timeout  out  1  sticky: the MDU stayed busy past the limit

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; all counters, resp_valid, resp_data and err_timeout are cleared to 0.
  - While reset=0, mdu_start=0 and mdu_operation=0 are forced.
  - The MDU is reset in the same cycle by the top level, so an operation in flight is abandoned; no result is expected after reset.
- State machine: IDLE, MUL_WAIT, DIV_WAIT. A wait counter (wcnt) is cleared on entry to each wait state.
- stall = req_valid & ~req_kill & (state!=IDLE | mdu_busy). This is combinational.
- accept = req_valid & ~req_kill & ~stall.
- Operation and start drive (combinational):
  - mdu_operation = accept ? req_op : 0 (READ_HI).
  - The MDU applies WRITE_HI/WRITE_LO whenever it is idle, even without start. Codes 2/3 therefore must never appear on mdu_operation except in an accept cycle.
  - mdu_start = accept & req_op[2].
  - mdu_operand1 = req_rs and mdu_operand2 = req_rt, always passed through.
- State transitions:
  - IDLE: accept with op 4/5 -> MUL_WAIT; accept with op 6/7 -> DIV_WAIT. Reads and writes stay in IDLE and complete in one cycle.
  - MUL_WAIT/DIV_WAIT: wcnt increments each cycle.
  - mdu_busy=0 -> IDLE. HI/LO are final at that point, so a read can be accepted in the next cycle.
  - Timeout: wcnt reaching MUL_CYCLES+TIMEOUT_SLACK (MUL_WAIT) or DIV_CYCLES+TIMEOUT_SLACK (DIV_WAIT) with mdu_busy still 1 sets err_timeout=1 and the state goes to IDLE. stall then follows mdu_busy only.
- Busy timing: mdu_busy rises the cycle after start. No second start can be issued in that gap because the state has already left IDLE.
- Read response: accept with op 0/1 at cycle T gives resp_valid=1 and resp_data=mdu_data_read(T) at T+1. Otherwise resp_valid=0 and resp_data holds its last value.
- req_kill:
  - Suppresses accept, start and the counter increments.
  - It does not abort an operation already in flight.
  - A killed request never stalls.
- Counters:
  - perf_mul_count increments on accepted op 4/5; perf_div_count increments on accepted op 6/7.
  - perf_stall_cycles increments on every cycle with stall=1.
  - All counters wrap modulo 2^32 with no saturation.
- err_timeout is cleared only by reset.

Test Plan:
- mtlo: req_rs=0x1234 op=3 -> mdu_operation=3 for exactly 1 cycle with start=0. Then op=1 -> resp_valid=1 and resp_data=0x1234 one cycle later.
- SMUL with rs=-3, rt=7: start=1 for 1 cycle, state MUL_WAIT. An mflo presented the next cycle stalls 5 cycles, is then accepted, and returns 0xFFFFFFEB. perf_mul_count=1 and perf_stall_cycles=5.
- UDIV with rs=100, rt=7, then mfhi back-to-back: stall held until mdu_busy falls. resp_data=2 (HI) and perf_div_count=1.
- req_kill asserted with a valid SDIV in IDLE -> mdu_start=0, stall=0, no state change, counters unchanged. Kill during DIV_WAIT does not shorten the wait.
- MDU model holding busy=1 forever after a MUL -> err_timeout=1 after 7 wait cycles, state IDLE, stall still follows busy. err_timeout stays 1 until reset.
- reset=0 during DIV_WAIT with req_valid=1 -> mdu_start=0, mdu_operation=0, all counters 0, resp_valid=0. The first request after reset=1 is accepted immediately.
